seq_addsub: RTL and testbench

Parametrised multi-cycle adder/subtractor, the registered successor to the team's single-bit behavioural full adder. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB first, through an internal CHUNK-bit ripple slice and a carry register. It uses a start/busy/done handshake and produces carry-out and signed-overflow flags. It sits beside the datapath wherever a wide add is needed without a full-width combinational carry chain.

---
 rtl/seq_addsub.sv | 143 ++++++++++++++
 tb/tb_seq_addsub.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub.sv
// ============================================================================
//  Module   : seq_addsub
//  Purpose  : Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock,
//             LSB first, with start/busy/done handshake, carry-out and signed
//             overflow. Optional macro SEQ_ADDSUB_SAT_EN enables saturation.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int c_k     = WIDTH / CHUNK;
    localparam int c_cnt_w = (c_k > 1) ? $clog2(c_k) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_k - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [CHUNK:0]     w_chunk_sum;
    logic [WIDTH-1:0]   w_res_next;
    logic [WIDTH-1:0]   w_s_final;
    logic               w_ovf;

    // Operand registers shift right each cycle, so the active chunk is always
    // in the low CHUNK bits; the result fills from the top down.
    assign w_chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, carry_q};
    assign w_res_next  = (res_q >> CHUNK)
                       | (WIDTH'(w_chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    // Carry into the MSB is recovered as a ^ b ^ sum at that bit position.
    assign w_ovf = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ w_chunk_sum[CHUNK-1]
                 ^ w_chunk_sum[CHUNK];

`ifdef SEQ_ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] c_sat_neg = WIDTH'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] c_sat_pos = ~c_sat_neg;
    assign w_s_final = !w_ovf ? w_res_next
                     : (a_q[CHUNK-1] ? c_sat_neg : c_sat_pos);
`else
    assign w_s_final = w_res_next;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy    = (state_q == S_RUN);
        done    = (state_q == S_DONE);

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = w_chunk_sum[CHUNK];
                res_d   = w_res_next;
                cnt_d   = cnt_q + c_cnt_w'(1);
                if (cnt_q == c_last) begin
                    state_d = S_DONE;
                    s_d     = w_s_final;
                    cout_d  = w_chunk_sum[CHUNK];
                    ovf_d   = w_ovf;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_addsub.sv
// ============================================================================
//  Module   : tb_seq_addsub
//  Purpose  : Scoreboard bench for seq_addsub (WIDTH=16, CHUNK=4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_addsub;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int K     = WIDTH / CHUNK;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [WIDTH-1:0]  a, b;
    logic              cin, sub;
    logic              busy, done, cout, ovf;
    logic [WIDTH-1:0]  s;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] last_s;

    seq_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Reference: true integer arithmetic, then wrap / range-check.
    function automatic exp_t model(input logic [WIDTH-1:0] ia, ib,
                                   input logic icin, isub);
        exp_t e;
        int sa, sb, ua, ub, ci, r, u;
        sa = $signed(ia);
        sb = $signed(ib);
        ua = int'(ia);
        ub = int'(ib);
        ci = icin ? 1 : 0;
        if (isub) begin
            r      = sa - sb - ci;
            u      = ua - ub - ci;
            e.cout = (ua >= ub + ci);
        end else begin
            r      = sa + sb + ci;
            u      = ua + ub + ci;
            e.cout = (u > 65535);
        end
        e.s   = u[WIDTH-1:0];
        e.ovf = (r > 32767) || (r < -32768);
`ifdef SEQ_ADDSUB_SAT_EN
        if (e.ovf) e.s = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: s=%0h with no pending operation", s);
                end else begin
                    e = exp_q.pop_front();
                    check("result_s", {16'h0, s}, {16'h0, e.s});
                    check("result_cout", {31'h0, cout}, {31'h0, e.cout});
                    check("result_ovf", {31'h0, ovf}, {31'h0, e.ovf});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic scramble();
        a   = WIDTH'($urandom);
        b   = WIDTH'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    // Called just after a posedge with the DUT in IDLE or DONE.
    task automatic issue(input logic [WIDTH-1:0] ia, ib, input logic icin, isub,
                         input bit poke);
        exp_t e;
        int   n;
        a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
        e = model(ia, ib, icin, isub);
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        check("busy_on_accept", {31'h0, busy}, 32'h1);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            check("s_hold", {16'h0, s}, {16'h0, last_s});
            if (poke && n == 1) begin
                start = 1'b1;
                scramble();
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("latency", n, K);
        check("busy_in_done", {31'h0, busy}, 32'h0);
        last_s = e.s;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; scramble();
        last_s = '0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_s", {16'h0, s}, 32'h0);
        check("rst_cout", {31'h0, cout}, 32'h0);
        check("rst_ovf", {31'h0, ovf}, 32'h0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", {31'h0, busy}, 32'h0);

        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
        idle(1);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        idle(2);
        issue(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
        issue(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
        idle(1);

        // Abort: reset lands during the third RUN cycle.
        a = 16'hABCD; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("abort_busy_on", {31'h0, busy}, 32'h1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        check("abort_s", {16'h0, s}, 32'h0);
        check("abort_cout", {31'h0, cout}, 32'h0);
        check("abort_ovf", {31'h0, ovf}, 32'h0);
        last_s = '0;
        idle(3);
        issue(16'h00F0, 16'h0F0F, 1'b1, 1'b0, 1'b0);
        idle(1);

        for (int i = 0; i < 30; i++) begin
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
                  bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        idle(4);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
